// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: decides PC / IF/ID / ID/EX advance, hold, flush
// and bubble each cycle, tracks imem wait timeouts, HALT, and stall/flush stats.
module pipeline_hazard_ctrl #(
    parameter int          TIMEOUT   = 16,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic [31:0]                IFID_Instruction,
    input  logic [4:0]                 IFID_Rs,
    input  logic [4:0]                 IFID_Rt,
    input  logic                       IFID_UsesRt,
    input  logic                       IDEX_MemRead,
    input  logic [4:0]                 IDEX_Rt,
    input  logic                       Jump_ID,
    input  logic                       Branch_Taken_EX,
    input  logic                       IMem_Ready,
    output logic                       PC_Write,
    output logic                       IFID_Write,
    output logic                       IFID_Flush,
    output logic                       IDEX_Bubble,
    output logic                       Halted,
    output logic                       Fault,
    output logic [CNT_W-1:0]           Stall_Cycles,
    output logic [CNT_W-1:0]           Flush_Count,
    output logic [1:0]                 Dbg_State,
    output logic [$clog2(TIMEOUT)-1:0] Dbg_WaitCnt
);

    localparam int WCW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_IWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WCW-1:0]   r_wait;
    logic             r_halted;
    logic             r_fault;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    state_t           w_next;
    logic [WCW-1:0]   w_wait_next;
    logic             w_pc;
    logic             w_ifid_w;
    logic             w_flush;
    logic             w_bubble;
    logic             w_fault_set;
    logic             w_flush_evt;
    logic             w_stall_evt;
    logic             w_lu;

    assign w_lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                  ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    // Priority decode; the wait counter only survives while staying in IWAIT.
    always_comb begin
        w_next      = r_state;
        w_wait_next = '0;
        w_pc        = 1'b0;
        w_ifid_w    = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_fault_set = 1'b0;
        w_flush_evt = 1'b0;
        case (r_state)
            S_HALT: begin
                w_bubble = 1'b1;
                w_next   = S_HALT;
            end
            default: begin
                if (Branch_Taken_EX) begin
                    w_pc        = 1'b1;
                    w_flush     = 1'b1;
                    w_bubble    = 1'b1;
                    w_flush_evt = 1'b1;
                    w_next      = S_RUN;
                end else if (w_lu) begin
                    w_bubble = 1'b1;
                    w_next   = S_RUN;
                end else if (Jump_ID) begin
                    w_pc        = 1'b1;
                    w_flush     = 1'b1;
                    w_flush_evt = 1'b1;
                    w_next      = S_RUN;
                end else if (!IMem_Ready) begin
                    w_flush = 1'b1;
                    if (r_wait == WCW'(TIMEOUT - 1)) begin
                        w_fault_set = 1'b1;
                        w_next      = S_HALT;
                    end else begin
                        w_next      = S_IWAIT;
                        w_wait_next = r_wait + 1'b1;
                    end
                end else if (IFID_Instruction == HALT_WORD) begin
                    w_bubble = 1'b1;
                    w_next   = S_HALT;
                end else begin
                    w_pc     = 1'b1;
                    w_ifid_w = 1'b1;
                    w_next   = S_RUN;
                end
            end
        endcase
    end

    assign w_stall_evt = (r_state != S_HALT) && !w_pc;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_RUN;
            r_wait      <= '0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_wait   <= w_wait_next;
            r_halted <= (w_next == S_HALT);
            if (w_fault_set)
                r_fault <= 1'b1;
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Reset forces the safe decision asynchronously, independent of the clock.
    assign PC_Write     = RESET_N && w_pc;
    assign IFID_Write   = RESET_N && w_ifid_w && !w_flush;
    assign IFID_Flush   = RESET_N && w_flush;
    assign IDEX_Bubble  = !RESET_N || w_bubble;
    assign Halted       = r_halted;
    assign Fault        = r_fault;
    assign Stall_Cycles = r_stall_cnt;
    assign Flush_Count  = r_flush_cnt;
    assign Dbg_State    = r_state;
    assign Dbg_WaitCnt  = r_wait;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4 and 4-bit counters so
// timeout and counter saturation are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [31:0] IFID_Instruction;
    logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
    logic        IFID_UsesRt, IDEX_MemRead, Jump_ID, Branch_Taken_EX, IMem_Ready;
    logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted, Fault;
    logic [CNT_W-1:0] Stall_Cycles, Flush_Count;
    logic [1:0]  Dbg_State;
    logic [1:0]  Dbg_WaitCnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_stall = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W), .HALT_WORD(32'hFFFFFFFF)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .IFID_Instruction(IFID_Instruction),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .Jump_ID(Jump_ID),
        .Branch_Taken_EX(Branch_Taken_EX), .IMem_Ready(IMem_Ready),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .Halted(Halted), .Fault(Fault),
        .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count),
        .Dbg_State(Dbg_State), .Dbg_WaitCnt(Dbg_WaitCnt)
    );

    // clock / reset
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        IFID_Instruction = 32'h0;
        IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
        Jump_ID = 1'b0; Branch_Taken_EX = 1'b0; IMem_Ready = 1'b1;
    endtask

    // Advance one rising edge; leaves time just after the following falling edge.
    task automatic tick();
        @(posedge CLOCK);
        @(negedge CLOCK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic pc, input logic ifw,
                             input logic fl, input logic bub);
        check({tag, ".pc"},   {31'b0, PC_Write},    {31'b0, pc});
        check({tag, ".ifw"},  {31'b0, IFID_Write},  {31'b0, ifw});
        check({tag, ".fl"},   {31'b0, IFID_Flush},  {31'b0, fl});
        check({tag, ".bub"},  {31'b0, IDEX_Bubble}, {31'b0, bub});
    endtask

    task automatic check_reset_vals(input string tag);
        check_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b1);
        check({tag, ".halted"}, {31'b0, Halted}, 32'd0);
        check({tag, ".fault"},  {31'b0, Fault},  32'd0);
        check({tag, ".stall"},  {28'b0, Stall_Cycles}, 32'd0);
        check({tag, ".flushc"}, {28'b0, Flush_Count},  32'd0);
        check({tag, ".state"},  {30'b0, Dbg_State},    32'd0);
        check({tag, ".wait"},   {30'b0, Dbg_WaitCnt},  32'd0);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    initial begin
        RESET_N = 1'b0;
        idle_inputs();
        #2;
        check_reset_vals("rst0");
        tick();
        check_reset_vals("rst1");
        RESET_N = 1'b1;
        settle();

        // normal advance
        check_ctl("run", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // load-use on Rs
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        settle();
        check_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        exp_stall = 1;
        check("lu_rs.stall", {28'b0, Stall_Cycles}, exp_stall);
        check("lu_rs.state", {30'b0, Dbg_State}, 32'd0);

        // bubble now in ID/EX: hazard gone
        idle_inputs();
        settle();
        check_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // load to r0 never stalls
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd5;
        settle();
        check_ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("lu_r0.stall", {28'b0, Stall_Cycles}, exp_stall);

        // Rt match only counts when the ID instruction reads Rt
        idle_inputs();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd7; IFID_Rs = 5'd3; IFID_Rt = 5'd7; IFID_UsesRt = 1'b0;
        settle();
        check_ctl("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
        IFID_UsesRt = 1'b1;
        settle();
        check_ctl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        exp_stall = 2;
        check("lu_rt.stall", {28'b0, Stall_Cycles}, exp_stall);

        // branch beats load-use
        idle_inputs();
        Branch_Taken_EX = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9;
        settle();
        check_ctl("br_lu", 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("br_lu.flushc", {28'b0, Flush_Count}, 32'd1);
        check("br_lu.stall", {28'b0, Stall_Cycles}, exp_stall);

        // jump beats imem wait
        idle_inputs();
        Jump_ID = 1'b1; IMem_Ready = 1'b0;
        settle();
        check_ctl("jmp_wait", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("jmp_wait.state", {30'b0, Dbg_State}, 32'd0);
        check("jmp_wait.wait", {30'b0, Dbg_WaitCnt}, 32'd0);
        check("jmp_wait.flushc", {28'b0, Flush_Count}, 32'd2);
        check("jmp_wait.stall", {28'b0, Stall_Cycles}, exp_stall);

        // three wait cycles then resume
        idle_inputs();
        IMem_Ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            settle();
            check_ctl($sformatf("iwait%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            exp_stall = sat_inc(exp_stall);
            check($sformatf("iwait%0d.state", i), {30'b0, Dbg_State}, 32'd1);
            check($sformatf("iwait%0d.wait", i), {30'b0, Dbg_WaitCnt}, i);
            check($sformatf("iwait%0d.stall", i), {28'b0, Stall_Cycles}, exp_stall);
        end
        IMem_Ready = 1'b1;
        settle();
        check_ctl("iwait_done", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("iwait_done.state", {30'b0, Dbg_State}, 32'd0);
        check("iwait_done.fault", {31'b0, Fault}, 32'd0);

        // drive the stall counter into saturation with sub-timeout waits
        for (int r = 0; r < 4; r++) begin
            IMem_Ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                exp_stall = sat_inc(exp_stall);
                check($sformatf("sat%0d_%0d.stall", r, i), {28'b0, Stall_Cycles}, exp_stall);
            end
            IMem_Ready = 1'b1;
            tick();
        end
        check("sat.final", {28'b0, Stall_Cycles}, 32'd15);
        check("sat.fault", {31'b0, Fault}, 32'd0);

        // timeout: fourth consecutive wait cycle faults
        IMem_Ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("to%0d.fault", i), {31'b0, Fault}, 32'd0);
            check($sformatf("to%0d.wait", i), {30'b0, Dbg_WaitCnt}, i);
        end
        settle();
        check_ctl("to4", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("to.fault", {31'b0, Fault}, 32'd1);
        check("to.halted", {31'b0, Halted}, 32'd1);
        check("to.state", {30'b0, Dbg_State}, 32'd2);
        check("to.wait", {30'b0, Dbg_WaitCnt}, 32'd0);
        check("to.stall", {28'b0, Stall_Cycles}, 32'd15);
        IMem_Ready = 1'b1;
        settle();
        check_ctl("to.halt_ctl", 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-cycle out of HALT
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_vals("rst_async");
        tick();
        RESET_N = 1'b1;
        idle_inputs();

        // HALT instruction
        IFID_Instruction = 32'hFFFFFFFF;
        settle();
        check_ctl("halt_instr", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("halt_instr.halted", {31'b0, Halted}, 32'd1);
        check("halt_instr.state", {30'b0, Dbg_State}, 32'd2);
        check("halt_instr.stall", {28'b0, Stall_Cycles}, 32'd1);
        IFID_Instruction = 32'h0;
        for (int i = 0; i < 20; i++) begin
            Branch_Taken_EX = i[0];
            Jump_ID = i[1];
            IMem_Ready = !i[2];
            settle();
            check_ctl($sformatf("halt%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            check($sformatf("halt%0d.halted", i), {31'b0, Halted}, 32'd1);
        end
        check("halt.stall", {28'b0, Stall_Cycles}, 32'd1);
        check("halt.flushc", {28'b0, Flush_Count}, 32'd0);
        check("halt.fault", {31'b0, Fault}, 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. Each cycle it decides whether the PC and the IF/ID register advance, hold or flush, and whether ID/EX receives a bubble. It resolves load-use hazards, taken branches (resolved in EX), jumps (resolved in ID), instruction-memory wait states and the HALT instruction. It also keeps saturating stall and flush statistics.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive instruction-memory wait cycles before a fault (≥2).
- CNT_W, 16: width of the statistics counters.
- HALT_WORD, 32'hFFFFFFFF: instruction encoding treated as HALT.

Ports:
- CLOCK  in  1  single clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IFID_Instruction  in  32  instruction currently held in IF/ID.
- IFID_Rs, IFID_Rt  in  5 each  source register fields of the ID instruction.
- IFID_UsesRt  in  1  ID instruction reads Rt.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination register of the load in EX.
- Jump_ID  in  1  jump decoded in ID.
- Branch_Taken_EX  in  1  branch resolved taken in EX.
- IMem_Ready  in  1  instruction memory returned a valid word this cycle.
- PC_Write  out  1  PC loads its next value.
- IFID_Write  out  1  IF/ID loads its inputs.
- IFID_Flush  out  1  IF/ID loads 32'h0 (nop); overrides IFID_Write.
- IDEX_Bubble  out  1  ID/EX loads all-zero control.
- Halted  out  1  registered; core has stopped.
- Fault  out  1  registered; instruction-memory timeout occurred.
- Stall_Cycles  out  CNT_W  registered; saturating count of cycles with PC_Write=0 in RUN/IWAIT.
- Flush_Count  out  CNT_W  registered; saturating count of branch/jump flush cycles.

## Operation
- States: RUN, IWAIT, HALT. Reset state is RUN.
- Load-use hazard (LU): IDEX_MemRead & IDEX_Rt≠0 & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
- In RUN and IWAIT, the first matching event in this priority order sets the outputs (Mealy, combinational):
  1. Branch_Taken_EX: PC_Write=1, IFID_Flush=1, IDEX_Bubble=1; Flush_Count+1; next RUN.
  2. LU: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next RUN.
  3. Jump_ID: PC_Write=1, IFID_Flush=1, IDEX_Bubble=0; Flush_Count+1; next RUN.
  4. !IMem_Ready: PC_Write=0, IFID_Flush=1; next IWAIT, wait counter +1.
  5. IFID_Instruction==HALT_WORD: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next HALT.
  6. Otherwise: PC_Write=1, IFID_Write=1; next RUN.
- Any output not listed for an event is 0.
- Wait counter: cleared whenever the next state is not IWAIT. If case 4 is chosen while the counter is TIMEOUT-1, Fault←1 and the next state is HALT.
- HALT: PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=1; Halted=1. HALT is left only by reset.
- Statistics counters saturate at all-ones and do not wrap.

## Timing
- Decisions are combinational within the cycle. State, wait counter, Halted, Fault and the statistics update on the same rising edge at which the pipeline registers act.
- A load-use stall lasts exactly 1 cycle. Next cycle ID/EX holds a bubble, so LU deasserts.
- Branch penalty: 2 cycles (IF/ID flush plus ID/EX bubble). Jump penalty: 1 cycle.
- An instruction-memory wait of N cycles produces N stall cycles. The first cycle with IMem_Ready=1 advances normally.
- While RESET_N=0, regardless of the clock: PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=1, Halted=0, Fault=0, Stall_Cycles=0, Flush_Count=0, state RUN, wait counter 0.
- Reset asserted mid-IWAIT or in HALT returns the block to RUN immediately.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 → one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1; Stall_Cycles=1. IFID_Rs=5 with IDEX_Rt=0 → no stall.
- Branch and LU in the same cycle → PC_Write=1, IFID_Flush=1, IDEX_Bubble=1; Flush_Count=1; Stall_Cycles unchanged.
- Jump_ID with IMem_Ready=0 → PC_Write=1, IFID_Flush=1; state stays RUN; wait counter 0.
- IMem_Ready low for 3 cycles → 3 cycles of PC_Write=0 with IFID_Flush=1 and state IWAIT, then RUN; Stall_Cycles=3; Fault=0.
- IMem_Ready held low with TIMEOUT=4 → after the 4th low cycle, Fault=1, Halted=1, all writes 0. RESET_N pulsed low → all outputs return to their reset values.
- IFID_Instruction=32'hFFFFFFFF with no hazard → next cycle Halted=1; PC_Write and IFID_Write stay 0 for 20 further cycles. Stall_Cycles preset near all-ones → saturates, no wrap.
